// File: rtl/framebuffer_write_controller.sv
// Sole write master for the cell framebuffer: sweeps full-screen clears to white
// and arbitrates them against cursor draw/erase writes, dropping redundant ones.
module framebuffer_write_controller #(
    parameter int GRID_W = 80,
    parameter int GRID_H = 60,
    parameter int X_W    = 7,
    parameter int Y_W    = 6
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           clear_request,
    input  logic           cursor_write_valid,
    input  logic [X_W-1:0] cursor_x,
    input  logic [Y_W-1:0] cursor_y,
    input  logic           cursor_pixel,
    output logic           write_enable,
    output logic [X_W-1:0] write_x,
    output logic [Y_W-1:0] write_y,
    output logic           write_pixel,
    output logic           clear_busy
);

    // state | meaning
    // IDLE  | pass cursor writes through, watch for clear_request rising edge
    // CLEAR | one white write per cycle, cursor requests parked in pending
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [X_W-1:0] X_LIM  = X_W'(GRID_W);
    localparam logic [Y_W-1:0] Y_LIM  = Y_W'(GRID_H);
    localparam logic [X_W-1:0] X_LAST = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(GRID_H - 1);

    state_t         state_q, state_d;
    logic [X_W-1:0] sx_q, sx_d;
    logic [Y_W-1:0] sy_q, sy_d;
    logic           clr_prev_q, clr_prev_d;

    logic           pend_valid_q, pend_valid_d;
    logic [X_W-1:0] pend_x_q, pend_x_d;
    logic [Y_W-1:0] pend_y_q, pend_y_d;
    logic           pend_pix_q, pend_pix_d;

    logic           last_valid_q, last_valid_d;
    logic [X_W-1:0] last_x_q, last_x_d;
    logic [Y_W-1:0] last_y_q, last_y_d;
    logic           last_pix_q, last_pix_d;

    logic           we_q, we_d;
    logic [X_W-1:0] wx_q, wx_d;
    logic [Y_W-1:0] wy_q, wy_d;
    logic           wpix_q, wpix_d;
    logic           busy_q, busy_d;

    logic clr_edge;
    logic cur_ok;
    logic cur_dup;
    logic pend_dup;

    always_comb begin
        clr_edge = clear_request & ~clr_prev_q;
        cur_ok   = cursor_write_valid && (cursor_x < X_LIM) && (cursor_y < Y_LIM);
        cur_dup  = last_valid_q && (cursor_x == last_x_q) && (cursor_y == last_y_q)
                   && (cursor_pixel == last_pix_q);
        pend_dup = last_valid_q && (pend_x_q == last_x_q) && (pend_y_q == last_y_q)
                   && (pend_pix_q == last_pix_q);

        state_d      = state_q;
        sx_d         = sx_q;
        sy_d         = sy_q;
        clr_prev_d   = clear_request;
        pend_valid_d = pend_valid_q;
        pend_x_d     = pend_x_q;
        pend_y_d     = pend_y_q;
        pend_pix_d   = pend_pix_q;
        last_valid_d = last_valid_q;
        last_x_d     = last_x_q;
        last_y_d     = last_y_q;
        last_pix_d   = last_pix_q;
        we_d         = 1'b0;
        wx_d         = wx_q;
        wy_d         = wy_q;
        wpix_d       = wpix_q;
        busy_d       = busy_q;

        case (state_q)
            CLEAR: begin
                we_d         = 1'b1;
                wx_d         = sx_q;
                wy_d         = sy_q;
                wpix_d       = 1'b1;
                busy_d       = 1'b1;
                last_valid_d = 1'b0;
                if (sx_q == X_LAST) begin
                    sx_d = '0;
                    if (sy_q == Y_LAST) begin
                        sy_d    = '0;
                        state_d = IDLE;
                    end else begin
                        sy_d = sy_q + 1'b1;
                    end
                end else begin
                    sx_d = sx_q + 1'b1;
                end
                // Latest request wins; the buffer is drained right after the sweep.
                if (cur_ok) begin
                    pend_valid_d = 1'b1;
                    pend_x_d     = cursor_x;
                    pend_y_d     = cursor_y;
                    pend_pix_d   = cursor_pixel;
                end
            end
            default: begin
                busy_d = 1'b0;
                if (clr_edge) begin
                    state_d      = CLEAR;
                    sx_d         = '0;
                    sy_d         = '0;
                    busy_d       = 1'b1;
                    last_valid_d = 1'b0;
                    if (cur_ok) begin
                        pend_valid_d = 1'b1;
                        pend_x_d     = cursor_x;
                        pend_y_d     = cursor_y;
                        pend_pix_d   = cursor_pixel;
                    end
                end else if (pend_valid_q) begin
                    pend_valid_d = 1'b0;
                    if (!pend_dup) begin
                        we_d         = 1'b1;
                        wx_d         = pend_x_q;
                        wy_d         = pend_y_q;
                        wpix_d       = pend_pix_q;
                        last_valid_d = 1'b1;
                        last_x_d     = pend_x_q;
                        last_y_d     = pend_y_q;
                        last_pix_d   = pend_pix_q;
                    end
                    // A request arriving while pending drains is kept for next cycle.
                    if (cur_ok) begin
                        pend_valid_d = 1'b1;
                        pend_x_d     = cursor_x;
                        pend_y_d     = cursor_y;
                        pend_pix_d   = cursor_pixel;
                    end
                end else if (cur_ok && !cur_dup) begin
                    we_d         = 1'b1;
                    wx_d         = cursor_x;
                    wy_d         = cursor_y;
                    wpix_d       = cursor_pixel;
                    last_valid_d = 1'b1;
                    last_x_d     = cursor_x;
                    last_y_d     = cursor_y;
                    last_pix_d   = cursor_pixel;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= CLEAR;
            sx_q         <= '0;
            sy_q         <= '0;
            clr_prev_q   <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_x_q     <= '0;
            pend_y_q     <= '0;
            pend_pix_q   <= 1'b0;
            last_valid_q <= 1'b0;
            last_x_q     <= '0;
            last_y_q     <= '0;
            last_pix_q   <= 1'b0;
            we_q         <= 1'b0;
            wx_q         <= '0;
            wy_q         <= '0;
            wpix_q       <= 1'b1;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            sx_q         <= sx_d;
            sy_q         <= sy_d;
            clr_prev_q   <= clr_prev_d;
            pend_valid_q <= pend_valid_d;
            pend_x_q     <= pend_x_d;
            pend_y_q     <= pend_y_d;
            pend_pix_q   <= pend_pix_d;
            last_valid_q <= last_valid_d;
            last_x_q     <= last_x_d;
            last_y_q     <= last_y_d;
            last_pix_q   <= last_pix_d;
            we_q         <= we_d;
            wx_q         <= wx_d;
            wy_q         <= wy_d;
            wpix_q       <= wpix_d;
            busy_q       <= busy_d;
        end
    end

    assign write_enable = we_q;
    assign write_x      = wx_q;
    assign write_y      = wy_q;
    assign write_pixel  = wpix_q;
    assign clear_busy   = busy_q;

endmodule

// File: tb/tb_framebuffer_write_controller.sv
// Scoreboard bench for framebuffer_write_controller: directed stimulus queues the
// expected writes, a negedge monitor pops and compares each observed write.
module tb_framebuffer_write_controller;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       clear_request = 1'b0;
    logic       cursor_write_valid = 1'b0;
    logic [6:0] cursor_x = '0;
    logic [5:0] cursor_y = '0;
    logic       cursor_pixel = 1'b0;
    logic       write_enable;
    logic [6:0] write_x;
    logic [5:0] write_y;
    logic       write_pixel;
    logic       clear_busy;

    framebuffer_write_controller #(
        .GRID_W(80), .GRID_H(60), .X_W(7), .Y_W(6)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .clear_request     (clear_request),
        .cursor_write_valid(cursor_write_valid),
        .cursor_x          (cursor_x),
        .cursor_y          (cursor_y),
        .cursor_pixel      (cursor_pixel),
        .write_enable      (write_enable),
        .write_x           (write_x),
        .write_y           (write_y),
        .write_pixel       (write_pixel),
        .clear_busy        (clear_busy)
    );

    always #5 clk = ~clk;

    // consec: this write must directly follow another write on the previous cycle
    typedef struct packed {
        logic [6:0] x;
        logic [5:0] y;
        logic       pix;
        logic       busy;
        logic       consec;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   wr_cnt = 0;
    logic prev_we = 1'b0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (write_enable) begin
                wr_cnt++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_write got (%0d,%0d,%0d) busy=%0d, expected no write",
                             write_x, write_y, write_pixel, clear_busy);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (write_x !== e.x || write_y !== e.y || write_pixel !== e.pix ||
                        clear_busy !== e.busy || (e.consec && !prev_we)) begin
                        fails++;
                        $display("FAIL write_check got (%0d,%0d,%0d) busy=%0d prev_we=%0d, expected (%0d,%0d,%0d) busy=%0d consec=%0d",
                                 write_x, write_y, write_pixel, clear_busy, prev_we,
                                 e.x, e.y, e.pix, e.busy, e.consec);
                    end
                end
            end
            prev_we = write_enable;
        end else begin
            prev_we = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push_sweep();
        exp_t e;
        for (int y = 0; y < 60; y++) begin
            for (int x = 0; x < 80; x++) begin
                e.x      = 7'(x);
                e.y      = 6'(y);
                e.pix    = 1'b1;
                e.busy   = 1'b1;
                e.consec = !(x == 0 && y == 0);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic push_write(input int x, input int y, input logic pix, input logic consec);
        exp_t e;
        e.x      = 7'(x);
        e.y      = 6'(y);
        e.pix    = pix;
        e.busy   = 1'b0;
        e.consec = consec;
        exp_q.push_back(e);
    endtask

    task automatic cursor(input int x, input int y, input logic pix, input int cycles);
        cursor_write_valid = 1'b1;
        cursor_x           = 7'(x);
        cursor_y           = 6'(y);
        cursor_pixel       = pix;
        idle(cycles);
        cursor_write_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_request = 1'b1;
        tick();
        clear_request = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s drain: %0d expected writes still outstanding after %0d cycles, expected 0",
                     name, exp_q.size(), budget);
            exp_q.delete();
        end
        idle(4);
    endtask

    task automatic check(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s got %0d expected %0d", name, got, want);
        end
    endtask

    initial begin
        int cnt;

        // Reset values while reset is held
        #22;
        check("rst_we",    int'(write_enable), 0);
        check("rst_x",     int'(write_x), 0);
        check("rst_y",     int'(write_y), 0);
        check("rst_pixel", int'(write_pixel), 1);
        check("rst_busy",  int'(clear_busy), 1);

        // Power-up sweep
        push_sweep();
        reset_n = 1'b1;
        wait_drain("powerup_sweep", 5000);
        check("idle_busy", int'(clear_busy), 0);
        check("idle_we",   int'(write_enable), 0);

        // Cursor writes and duplicate suppression
        push_write(10, 20, 1'b0, 1'b0);
        cursor(10, 20, 1'b0, 1);
        wait_drain("cursor_single", 10);
        cnt = wr_cnt;
        cursor(10, 20, 1'b0, 5);
        idle(4);
        check("dup_held_suppressed", wr_cnt - cnt, 0);
        push_write(10, 20, 1'b1, 1'b0);
        cursor(10, 20, 1'b1, 5);
        wait_drain("cursor_pixel_change", 10);

        // Clear level held high: exactly one sweep
        push_sweep();
        clear_request = 1'b1;
        cnt = wr_cnt;
        idle(10000);
        clear_request = 1'b0;
        check("held_clear_writes", wr_cnt - cnt, 4800);
        wait_drain("held_clear", 10);

        // Cursor requests during a sweep, latest wins
        push_sweep();
        push_write(5, 6, 1'b0, 1'b1);
        pulse_clear();
        idle(100);
        cursor(3, 4, 1'b0, 1);
        idle(50);
        cursor(5, 6, 1'b0, 1);
        wait_drain("pending_latest", 5000);

        // Same-cycle clear edge and cursor request
        push_sweep();
        push_write(7, 7, 1'b0, 1'b1);
        clear_request = 1'b1;
        cursor(7, 7, 1'b0, 1);
        clear_request = 1'b0;
        wait_drain("clear_plus_cursor", 5000);
        cnt = wr_cnt;
        cursor(7, 7, 1'b0, 1);
        idle(5);
        check("repeat_suppressed", wr_cnt - cnt, 0);
        push_sweep();
        pulse_clear();
        wait_drain("reclear", 5000);
        push_write(7, 7, 1'b0, 1'b0);
        cursor(7, 7, 1'b0, 1);
        wait_drain("repeat_after_clear", 10);

        // Out-of-range coordinates dropped
        cnt = wr_cnt;
        cursor(80, 0, 1'b0, 1);
        cursor(0, 60, 1'b0, 1);
        cursor(127, 63, 1'b1, 2);
        idle(5);
        check("out_of_range_dropped", wr_cnt - cnt, 0);
        check("out_of_range_busy", int'(clear_busy), 0);

        // Reset mid-sweep
        push_sweep();
        pulse_clear();
        idle(2000);
        check("midsweep_we_before_reset", int'(write_enable), 1);
        reset_n = 1'b0;
        #1;
        check("async_rst_we",    int'(write_enable), 0);
        check("async_rst_x",     int'(write_x), 0);
        check("async_rst_pixel", int'(write_pixel), 1);
        check("async_rst_busy",  int'(clear_busy), 1);
        exp_q.delete();
        #20;
        push_sweep();
        reset_n = 1'b1;
        wait_drain("sweep_after_reset", 5000);
        check("final_busy", int'(clear_busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/framebuffer_write_controller.md
Name: framebuffer_write_controller

Overview:
- Sole write master for the cell framebuffer; sits between the cursor block and the framebuffer write port.
- Sequences full-screen clears by sweeping every cell to white, one cell per clock, and arbitrates those writes against cursor draw/erase writes.
- Performs an automatic clear after reset, so the board always powers up with a white whiteboard.
- Suppresses redundant cursor writes; the VGA read side is untouched.

Parameters:
- GRID_W, 80, cells per row; cursor_x values >= GRID_W are invalid.
- GRID_H, 60, cells per column; cursor_y values >= GRID_H are invalid.
- X_W, 7, width of x coordinates.
- Y_W, 6, width of y coordinates.

Ports:
- clk  input  1  pixel-domain clock (divided clock); all logic is on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- clear_request  input  1  level from the clear control, already synchronous to clk; its rising edge requests a clear.
- cursor_write_valid  input  1  cursor requests a write this cycle.
- cursor_x  input  X_W  cursor cell column.
- cursor_y  input  Y_W  cursor cell row.
- cursor_pixel  input  1  value to write: 1 = white (erase), 0 = black (draw).
- write_enable  output  1  framebuffer write strobe, one cell per cycle.
- write_x  output  X_W  write column.
- write_y  output  Y_W  write row.
- write_pixel  output  1  write data.
- clear_busy  output  1  high while a clear sweep is in progress.

Behaviour:
- Outputs: all registered. Reset values are write_enable=0, write_x=0, write_y=0, write_pixel=1, clear_busy=1.
- Reset state: async reset forces state CLEAR with sweep counters at (0,0). It also clears the pending buffer, the last-write register and the clear_request edge register (registered as 0).
- States: IDLE and CLEAR only.
- CLEAR sweep:
  - Each cycle issues write_enable=1, write_pixel=1 at the counter position.
  - x increments first; when x wraps GRID_W-1 -> 0, y increments.
  - The first write appears in the cycle after the first clk edge following reset release or clear entry.
  - Exactly GRID_W*GRID_H consecutive writes; the last write is at (GRID_W-1, GRID_H-1).
  - clear_busy is 1 during every sweep write and falls to 0 the cycle after the last one.
- CLEAR exit:
  - If pending is valid, the cycle after the last sweep write issues the pending write and clears pending. Otherwise write_enable=0.
  - State returns to IDLE.
  - The last-write register is invalidated on every clear.
- IDLE:
  - A rising edge of clear_request moves to CLEAR with counters at (0,0).
  - Otherwise, a cursor_write_valid with in-range coordinates is issued one cycle later (write_enable=1, registered x/y/pixel).
  - A cursor write is suppressed if (x,y,pixel) equals the last-write register and that register is valid.
  - Each issued cursor write updates the last-write register.
- Cursor writes during CLEAR:
  - Captured into a one-entry pending buffer; a later request overwrites it (latest wins).
  - Out-of-range requests are dropped.
- Clear edge and cursor_write_valid in the same IDLE cycle: the clear wins. The cursor request goes to pending and is written after the sweep.
- Clear edge during CLEAR: ignored. The sweep is not restarted and nothing is queued.
- Out-of-range cursor coordinates: dropped in every state, with no write and no state change.
- Reset asserted mid-sweep or mid-write: outputs go to their reset values immediately (async). On release, a fresh full sweep starts from (0,0).
- write_enable is 0 in any cycle with no sweep write, pending write or accepted cursor write.
- write_x and write_y hold their last value when write_enable=0; the framebuffer ignores them.

Test Plan:
- Release reset, no inputs -> 4800 consecutive write_enable=1 cycles, pixel=1, order (0,0),(1,0)..(79,0),(0,1)..(79,59). clear_busy falls the cycle after (79,59). Then write_enable=0.
- In IDLE, cursor_write_valid with (10,20,0) for 1 cycle -> one write (10,20,0) the next cycle. The same request held for 5 cycles -> still exactly one write. Then (10,20,1) -> one write (10,20,1).
- In IDLE, raise clear_request and hold it high for 10000 cycles -> exactly one 4800-cycle sweep; no second sweep while the level stays high.
- During a sweep, cursor requests (3,4,0) then (5,6,0) -> no cursor write mid-sweep; a single write (5,6,0) the cycle after the (79,59) sweep write.
- Same-cycle clear edge plus cursor (7,7,0) in IDLE -> sweep starts next cycle; (7,7,0) is written right after the sweep. A repeat of (7,7,0) after that is suppressed; a repeat after a further clear is written.
- Cursor (80,0,0) and (0,60,0) in IDLE -> no writes. Pulse reset_n low at sweep write ~2000 -> write_enable=0 immediately; after release the sweep restarts at (0,0).
